// File: rtl/hermes_pkt_injector.sv
// Memory-mapped Hermes packet transmitter: CPU fills a payload FIFO, then the block emits
// header, size and payload flits to the router local port under credit flow control.
module hermes_pkt_injector #(
    parameter int unsigned FLIT_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_en_i,
    input  logic [3:0]           cfg_we_i,
    input  logic [31:0]          cfg_addr_i,
    input  logic [31:0]          cfg_data_i,
    output logic [31:0]          cfg_data_o,
    output logic                 irq_o,
    output logic                 noc_tx_o,
    input  logic                 noc_credit_i,
    output logic [FLIT_SIZE-1:0] noc_data_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    localparam logic [2:0] AddrTarget = 3'd0;
    localparam logic [2:0] AddrSize   = 3'd1;
    localparam logic [2:0] AddrPush   = 3'd2;
    localparam logic [2:0] AddrStart  = 3'd3;
    localparam logic [2:0] AddrStatus = 3'd4;
    localparam logic [2:0] AddrAck    = 3'd5;

    typedef enum logic [1:0] {StIdle, StHdr, StLen, StPld} state_e;

    state_e             state_q, state_d;
    logic [15:0]        target_q, target_d;
    logic [15:0]        size_q, size_d;
    logic [15:0]        tgt_lat_q, tgt_lat_d;
    logic [15:0]        rem_q, rem_d;
    logic               irq_q, irq_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        cfg_data_q, cfg_data_d;
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q;
    logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic [2:0] addr;
    logic       wr_en, rd_en;
    logic       push_req, push, pop, fifo_empty, fifo_full;
    logic       start_wr, ack_wr, irq_set;
    logic       tx;
    logic [FLIT_SIZE-1:0] tx_data;
    logic       unused_addr;

    assign addr        = cfg_addr_i[4:2];
    assign unused_addr = ^{cfg_addr_i[31:5], cfg_addr_i[1:0]};
    assign wr_en       = cfg_en_i && (cfg_we_i == 4'hF);
    assign rd_en       = cfg_en_i && (cfg_we_i == 4'h0);
    assign start_wr    = wr_en && (addr == AddrStart);
    assign ack_wr      = wr_en && (addr == AddrAck);
    assign push_req    = wr_en && (addr == AddrPush);

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CntFull);
    assign push        = push_req && !fifo_full;
    assign pop         = (state_q == StPld) && !fifo_empty && noc_credit_i;

    // Register file writes; TARGET/SIZE stay writable while busy since the packet uses latches.
    always_comb begin
        target_d = target_q;
        size_d   = size_q;
        if (wr_en && (addr == AddrTarget)) target_d = cfg_data_i[15:0];
        if (wr_en && (addr == AddrSize))   size_d   = cfg_data_i[15:0];
    end

    always_comb begin
        state_d   = state_q;
        tgt_lat_d = tgt_lat_q;
        rem_d     = rem_q;
        irq_set   = 1'b0;
        tx        = 1'b0;
        tx_data   = '0;
        unique case (state_q)
            StIdle: begin
                if (start_wr) begin
                    tgt_lat_d = target_q;
                    rem_d     = size_q;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                tx      = 1'b1;
                tx_data = {{(FLIT_SIZE-16){1'b0}}, tgt_lat_q};
                if (noc_credit_i) state_d = StLen;
            end
            StLen: begin
                tx      = 1'b1;
                tx_data = {{(FLIT_SIZE-16){1'b0}}, rem_q};
                if (noc_credit_i) begin
                    if (rem_q == 16'd0) begin
                        irq_set = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StPld;
                    end
                end
            end
            StPld: begin
                tx      = !fifo_empty;
                tx_data = fifo_empty ? '0 : mem_q[rd_ptr_q];
                if (pop) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        irq_set = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completion set wins over a simultaneous acknowledge; same for overflow.
    always_comb begin
        irq_d = irq_q;
        ovf_d = ovf_q;
        if (ack_wr && cfg_data_i[0]) irq_d = 1'b0;
        if (ack_wr && cfg_data_i[1]) ovf_d = 1'b0;
        if (irq_set)                 irq_d = 1'b1;
        if (push_req && fifo_full)   ovf_d = 1'b1;
    end

    always_comb begin
        cfg_data_d = cfg_data_q;
        if (rd_en) begin
            unique case (addr)
                AddrTarget: cfg_data_d = {16'b0, target_q};
                AddrSize:   cfg_data_d = {16'b0, size_q};
                AddrStatus: cfg_data_d = {(state_q != StIdle), ovf_q, irq_q, 13'b0,
                                          16'(count_q)};
                default:    cfg_data_d = 32'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            target_q   <= '0;
            size_q     <= '0;
            tgt_lat_q  <= '0;
            rem_q      <= '0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cfg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            size_q     <= size_d;
            tgt_lat_q  <= tgt_lat_d;
            rem_q      <= rem_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset; reads are gated by the count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= FLIT_SIZE'(cfg_data_i);
    end

    assign cfg_data_o = cfg_data_q;
    assign irq_o      = irq_q;
    assign noc_tx_o   = tx;
    assign noc_data_o = tx_data;

endmodule

// File: tb/tb_hermes_pkt_injector.sv
// Directed self-checking bench for hermes_pkt_injector.
module tb_hermes_pkt_injector;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_en_i;
    logic [3:0]  cfg_we_i;
    logic [31:0] cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic [31:0] cfg_data_o;
    logic        irq_o;
    logic        noc_tx_o;
    logic        noc_credit_i;
    logic [31:0] noc_data_o;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] rdv;

    hermes_pkt_injector #(.FLIT_SIZE(32), .FIFO_DEPTH(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_en_i    (cfg_en_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_data_i  (cfg_data_i),
        .cfg_data_o  (cfg_data_o),
        .irq_o       (irq_o),
        .noc_tx_o    (noc_tx_o),
        .noc_credit_i(noc_credit_i),
        .noc_data_o  (noc_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [31:0] d,
                          input logic [3:0] we = 4'hF);
        cfg_en_i   = 1'b1;
        cfg_we_i   = we;
        cfg_addr_i = {27'b0, off, 2'b00};
        cfg_data_i = d;
        tick();
        cfg_en_i   = 1'b0;
        cfg_we_i   = 4'h0;
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [31:0] d);
        cfg_en_i   = 1'b1;
        cfg_we_i   = 4'h0;
        cfg_addr_i = {27'b0, off, 2'b00};
        tick();
        cfg_en_i   = 1'b0;
        d = cfg_data_o;
    endtask

    // Check one flit on the wire, then let it transfer.
    task automatic flit(input string tag, input logic [31:0] exp);
        chk({tag, "_tx"}, {31'b0, noc_tx_o}, 32'd1);
        chk(tag, noc_data_o, exp);
        tick();
    endtask

    initial begin
        rst_ni       = 1'b0;
        cfg_en_i     = 1'b0;
        cfg_we_i     = 4'h0;
        cfg_addr_i   = '0;
        cfg_data_i   = '0;
        noc_credit_i = 1'b1;
        #1;
        chk("rst_tx", {31'b0, noc_tx_o}, 32'd0);
        chk("rst_data", noc_data_o, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_cfg", cfg_data_o, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Partial byte enables must not write.
        bus_wr(3'd0, 32'h0000_FFFF, 4'h3);
        bus_rd(3'd0, rdv);
        chk("partial_we", rdv, 32'd0);

        // 1: basic three-word packet
        bus_wr(3'd0, 32'h0000_0102);
        bus_wr(3'd1, 32'd3);
        bus_wr(3'd2, 32'hA000_000A);
        bus_wr(3'd2, 32'hB000_000B);
        bus_wr(3'd2, 32'hC000_000C);
        bus_rd(3'd0, rdv);
        chk("s1_target_rd", rdv, 32'h0000_0102);
        bus_wr(3'd3, 32'd1);
        flit("s1_hdr", 32'h0000_0102);
        flit("s1_len", 32'd3);
        flit("s1_a", 32'hA000_000A);
        flit("s1_b", 32'hB000_000B);
        flit("s1_c", 32'hC000_000C);
        chk("s1_tx_end", {31'b0, noc_tx_o}, 32'd0);
        chk("s1_irq", {31'b0, irq_o}, 32'd1);
        bus_rd(3'd4, rdv);
        chk("s1_status", rdv, 32'h2000_0000);
        bus_wr(3'd5, 32'd1);
        chk("s1_ack", {31'b0, irq_o}, 32'd0);

        // 2: credit stall during the second payload flit
        bus_wr(3'd2, 32'hA200_0001);
        bus_wr(3'd2, 32'hB200_0002);
        bus_wr(3'd2, 32'hC200_0003);
        bus_wr(3'd3, 32'd0);
        flit("s2_hdr", 32'h0000_0102);
        flit("s2_len", 32'd3);
        flit("s2_a", 32'hA200_0001);
        noc_credit_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s2_hold_tx", {31'b0, noc_tx_o}, 32'd1);
            chk("s2_hold_b", noc_data_o, 32'hB200_0002);
            tick();
        end
        noc_credit_i = 1'b1;
        flit("s2_b", 32'hB200_0002);
        flit("s2_c", 32'hC200_0003);
        chk("s2_tx_end", {31'b0, noc_tx_o}, 32'd0);
        chk("s2_irq", {31'b0, irq_o}, 32'd1);
        bus_wr(3'd5, 32'd1);

        // 3: empty payload leaves the FIFO untouched
        bus_wr(3'd2, 32'h7777_0000);
        bus_wr(3'd1, 32'd0);
        bus_wr(3'd3, 32'd1);
        flit("s3_hdr", 32'h0000_0102);
        flit("s3_len", 32'd0);
        chk("s3_tx_end", {31'b0, noc_tx_o}, 32'd0);
        chk("s3_irq", {31'b0, irq_o}, 32'd1);
        bus_rd(3'd4, rdv);
        chk("s3_status", rdv, 32'h2000_0001);
        bus_wr(3'd5, 32'd1);

        // 4: overflow, then drain all 16 (one leftover plus 15 new) across a pointer wrap
        for (int i = 0; i < 17; i++) bus_wr(3'd2, 32'h5000_0000 + 32'(i));
        bus_rd(3'd4, rdv);
        chk("s4_status_ovf", rdv, 32'h4000_0010);
        bus_wr(3'd5, 32'd2);
        bus_rd(3'd4, rdv);
        chk("s4_status_ack", rdv, 32'h0000_0010);
        bus_wr(3'd1, 32'd16);
        bus_wr(3'd3, 32'd1);
        flit("s4_hdr", 32'h0000_0102);
        flit("s4_len", 32'd16);
        flit("s4_left", 32'h7777_0000);
        for (int i = 0; i < 15; i++) flit("s4_pld", 32'h5000_0000 + 32'(i));
        chk("s4_irq", {31'b0, irq_o}, 32'd1);
        bus_rd(3'd4, rdv);
        chk("s4_status_end", rdv, 32'h2000_0000);
        bus_wr(3'd5, 32'd1);

        // 5: start with empty FIFO, payload trickles in
        bus_wr(3'd1, 32'd4);
        bus_wr(3'd3, 32'd1);
        flit("s5_hdr", 32'h0000_0102);
        flit("s5_len", 32'd4);
        chk("s5_wait_tx", {31'b0, noc_tx_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_wr(3'd2, 32'hD000_0000 + 32'(i));
            flit("s5_pld", 32'hD000_0000 + 32'(i));
            chk("s5_gap_tx", {31'b0, noc_tx_o}, 32'd0);
            chk("s5_irq", {31'b0, irq_o}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end

        // 6: asynchronous reset mid-payload (irq still set from 5)
        bus_wr(3'd1, 32'd3);
        for (int i = 0; i < 3; i++) bus_wr(3'd2, 32'hE000_0000 + 32'(i));
        bus_wr(3'd3, 32'd1);
        flit("s6_hdr", 32'h0000_0102);
        flit("s6_len", 32'd3);
        flit("s6_p0", 32'hE000_0000);
        rst_ni = 1'b0;
        #1;
        chk("s6_rst_tx", {31'b0, noc_tx_o}, 32'd0);
        chk("s6_rst_data", noc_data_o, 32'd0);
        chk("s6_rst_irq", {31'b0, irq_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        bus_rd(3'd4, rdv);
        chk("s6_status", rdv, 32'h0000_0000);
        bus_rd(3'd0, rdv);
        chk("s6_target", rdv, 32'h0000_0000);
        bus_wr(3'd0, 32'h0000_0A0B);
        bus_wr(3'd1, 32'd1);
        bus_wr(3'd2, 32'hF00D_0001);
        bus_wr(3'd3, 32'd1);
        flit("s6n_hdr", 32'h0000_0A0B);
        flit("s6n_len", 32'd1);
        flit("s6n_p0", 32'hF00D_0001);
        chk("s6n_tx_end", {31'b0, noc_tx_o}, 32'd0);
        chk("s6n_irq", {31'b0, irq_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
